ascii_result_tx: RTL

Converts a binary sum from the 7-bit ASCII adder datapath (7-bit result plus carry, range 0..255) into a stream of ASCII decimal digit characters. The digits go out one character per valid/ready handshake, most significant first, followed by an optional terminator. The block sits between the adder result and the character output path (UART/display), and does the reverse of the ASCII-to-binary input side. Binary-to-BCD conversion is sequential (shift-and-add-3, one bit per cycle).

---
 rtl/ascii_result_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ascii_result_tx.sv
// Converts an 8-bit adder sum (0..255) into ASCII decimal digits, most significant first,
// with leading zeros suppressed and an optional terminator, one character per valid/ready transfer.
module ascii_result_tx #(
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [6:0] TERM_CHAR = 7'h0D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_in,
    output logic [6:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } state_t;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        if (nib >= 4'd5) begin
            add3 = nib + 4'd3;
        end else begin
            add3 = nib;
        end
    endfunction

    function automatic logic [6:0] digit_char(input logic [3:0] nib);
        digit_char = 7'h30 + {3'b000, nib};
    endfunction

    state_t          state_r, state_next_s;
    logic [7:0]      bin_r, bin_next_s;
    logic [11:0]     bcd_r, bcd_next_s;
    logic [3:0]      cnt_r, cnt_next_s;
    logic [3:0][6:0] chars_r, chars_next_s;
    logic [1:0]      last_r, last_next_s;
    logic [1:0]      idx_r, idx_next_s;
    logic [6:0]      char_out_r, char_out_next_s;
    logic            char_valid_r, char_valid_next_s;
    logic            busy_r, busy_next_s;
    logic            done_r, done_next_s;

    logic [19:0]     step_s;
    logic [3:0]      h_s, t_s, u_s;
    logic [3:0][6:0] list_s;
    logic [1:0]      list_last_s;
    logic [1:0]      idx_inc_s;

    // One shift-and-add-3 step over {H,T,U,bin}
    assign step_s    = {add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0]), bin_r} << 5'd1;
    assign h_s       = step_s[19:16];
    assign t_s       = step_s[15:12];
    assign u_s       = step_s[11:8];
    assign idx_inc_s = idx_r + 2'd1;

    // Character list from the final BCD value; only meaningful on the last conversion step
    always_comb begin
        list_s      = '0;
        list_last_s = 2'd0;
        if (h_s != 4'd0) begin
            list_s[0]   = digit_char(h_s);
            list_s[1]   = digit_char(t_s);
            list_s[2]   = digit_char(u_s);
            list_s[3]   = TERM_CHAR;
            list_last_s = TERM_EN ? 2'd3 : 2'd2;
        end else if (t_s != 4'd0) begin
            list_s[0]   = digit_char(t_s);
            list_s[1]   = digit_char(u_s);
            list_s[2]   = TERM_CHAR;
            list_last_s = TERM_EN ? 2'd2 : 2'd1;
        end else begin
            list_s[0]   = digit_char(u_s);
            list_s[1]   = TERM_CHAR;
            list_last_s = TERM_EN ? 2'd1 : 2'd0;
        end
    end

    // Next-state and next-output logic; outputs are computed here and registered below
    always_comb begin
        state_next_s      = state_r;
        bin_next_s        = bin_r;
        bcd_next_s        = bcd_r;
        cnt_next_s        = cnt_r;
        chars_next_s      = chars_r;
        last_next_s       = last_r;
        idx_next_s        = idx_r;
        char_out_next_s   = char_out_r;
        char_valid_next_s = char_valid_r;
        busy_next_s       = busy_r;
        done_next_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = CONV;
                    bin_next_s   = num_in;
                    bcd_next_s   = 12'h000;
                    cnt_next_s   = 4'd8;
                    busy_next_s  = 1'b1;
                end else begin
                    busy_next_s  = 1'b0;
                end
            end
            CONV: begin
                bin_next_s = step_s[7:0];
                bcd_next_s = step_s[19:8];
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_next_s      = SEND;
                    chars_next_s      = list_s;
                    last_next_s       = list_last_s;
                    idx_next_s        = 2'd0;
                    char_out_next_s   = list_s[0];
                    char_valid_next_s = 1'b1;
                end else begin
                    state_next_s      = CONV;
                end
            end
            SEND: begin
                if (char_ready) begin
                    if (idx_r == last_r) begin
                        state_next_s      = FIN;
                        char_valid_next_s = 1'b0;
                        busy_next_s       = 1'b0;
                        done_next_s       = 1'b1;
                    end else begin
                        idx_next_s        = idx_inc_s;
                        char_out_next_s   = chars_r[idx_inc_s];
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            FIN: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s      = IDLE;
                char_valid_next_s = 1'b0;
                busy_next_s       = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            bin_r        <= 8'h00;
            bcd_r        <= 12'h000;
            cnt_r        <= 4'd0;
            chars_r      <= '0;
            last_r       <= 2'd0;
            idx_r        <= 2'd0;
            char_out_r   <= 7'h00;
            char_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            bin_r        <= bin_next_s;
            bcd_r        <= bcd_next_s;
            cnt_r        <= cnt_next_s;
            chars_r      <= chars_next_s;
            last_r       <= last_next_s;
            idx_r        <= idx_next_s;
            char_out_r   <= char_out_next_s;
            char_valid_r <= char_valid_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    assign char_out   = char_out_r;
    assign char_valid = char_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule
